// File: rtl/st7735_sink.sv
// Receive-side model of the ST7735 4-wire SPI link: oversamples cs/sclk/mosi/dc,
// deframes bytes, decodes CASET/RASET/RAMWR and emits one strobe per written pixel.
module st7735_sink #(
   parameter int unsigned C_color_bits = 16,
   parameter int unsigned C_x_bits     = 8,
   parameter int unsigned C_y_bits     = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    oled_cs,
   input  logic                    oled_clk,
   input  logic                    oled_mosi,
   input  logic                    oled_dc,
   input  logic                    lcd_resetn,
   output logic                    cmd_valid,
   output logic [7:0]              cmd,
   output logic                    pixel_valid,
   output logic [C_x_bits-1:0]     px_x,
   output logic [C_y_bits-1:0]     px_y,
   output logic [C_color_bits-1:0] px_color,
   output logic                    frame_done
);

   typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_SKIP} state_t;

   typedef struct packed {
      logic                    rise;
      logic                    mosi;
      logic                    dc;
      logic [6:0]              shift;
      logic [2:0]              bit_cnt;
      logic                    byte_vld;
      logic [7:0]              byte_dat;
      logic                    byte_dc;
      state_t                  state;
      logic [1:0]              arg;
      logic [7:0]              arg_hi;
      logic [C_x_bits-1:0]     xs_tmp;
      logic [C_y_bits-1:0]     ys_tmp;
      logic [C_x_bits-1:0]     xs;
      logic [C_x_bits-1:0]     xe;
      logic [C_x_bits-1:0]     x;
      logic [C_y_bits-1:0]     ys;
      logic [C_y_bits-1:0]     ye;
      logic [C_y_bits-1:0]     y;
      logic                    half_vld;
      logic [7:0]              half;
      logic                    cmd_valid;
      logic [7:0]              cmd;
      logic                    pixel_valid;
      logic [C_x_bits-1:0]     px_x;
      logic [C_y_bits-1:0]     px_y;
      logic [C_color_bits-1:0] px_color;
      logic                    frame_done;
   } core_t;

   function automatic core_t core_rst();
      core_t r;
      r       = '0;
      r.state = S_IDLE;
      r.xe    = C_x_bits'(127);
      r.ye    = C_y_bits'(159);
      return r;
   endfunction

   logic [1:0] cs_sync, sclk_sync, mosi_sync, dc_sync, lrst_sync;
   logic       sclk_prev, cs_prev;
   logic       cs_s, sclk_s;

   core_t q, d;
   logic                    emit;
   logic [C_color_bits-1:0] emit_color;
   logic [15:0]             arg_val;

   assign cs_s   = cs_sync[1];
   assign sclk_s = sclk_sync[1];

   // Two-flop synchronizers; only resetn touches them so lcd_resetn can release itself
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cs_sync   <= 2'b11;
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         dc_sync   <= 2'b00;
         lrst_sync <= 2'b00;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         cs_sync   <= {cs_sync[0], oled_cs};
         sclk_sync <= {sclk_sync[0], oled_clk};
         mosi_sync <= {mosi_sync[0], oled_mosi};
         dc_sync   <= {dc_sync[0], oled_dc};
         lrst_sync <= {lrst_sync[0], lcd_resetn};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   // Core state register; synced lcd_resetn low acts as a synchronous full reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)            q <= core_rst();
      else if (!lrst_sync[1]) q <= core_rst();
      else                    q <= d;
   end

   always_comb begin
      d             = q;
      emit          = 1'b0;
      emit_color    = '0;
      arg_val       = {q.arg_hi, q.byte_dat};
      d.cmd_valid   = 1'b0;
      d.pixel_valid = 1'b0;
      d.frame_done  = 1'b0;
      d.byte_vld    = 1'b0;

      // Edge stage: mosi/dc taken from the same synced stage as the sclk rise
      d.rise = sclk_s & ~sclk_prev & ~cs_prev;
      d.mosi = mosi_sync[1];
      d.dc   = dc_sync[1];

      // Deframer: a rise always wins over a simultaneous cs clear
      if (q.rise) begin
         d.shift   = {q.shift[5:0], q.mosi};
         d.bit_cnt = q.bit_cnt + 3'd1;
         if (q.bit_cnt == 3'd7) begin
            d.byte_vld = 1'b1;
            d.byte_dat = {q.shift, q.mosi};
            d.byte_dc  = q.dc;
         end
      end else if (cs_s) begin
         d.bit_cnt = '0;
      end

      if (q.byte_vld) begin
         if (!q.byte_dc) begin
            d.cmd_valid = 1'b1;
            d.cmd       = q.byte_dat;
            d.half_vld  = 1'b0;
            d.arg       = '0;
            case (q.byte_dat)
               8'h2A:   d.state = S_CASET;
               8'h2B:   d.state = S_RASET;
               8'h2C: begin
                  d.state = S_RAMWR;
                  d.x     = q.xs;
                  d.y     = q.ys;
               end
               default: d.state = S_SKIP;
            endcase
         end else begin
            case (q.state)
               S_CASET, S_RASET: begin
                  d.arg = q.arg + 2'd1;
                  if (!q.arg[0]) begin
                     d.arg_hi = q.byte_dat;
                  end else if (q.arg == 2'd1) begin
                     d.xs_tmp = C_x_bits'(arg_val);
                     d.ys_tmp = C_y_bits'(arg_val);
                  end else begin
                     if (q.state == S_CASET) begin
                        d.xs = q.xs_tmp;
                        d.xe = C_x_bits'(arg_val);
                     end else begin
                        d.ys = q.ys_tmp;
                        d.ye = C_y_bits'(arg_val);
                     end
                     d.state = S_IDLE;
                  end
               end
               S_RAMWR: begin
                  if (C_color_bits == 16 && !q.half_vld) begin
                     d.half     = q.byte_dat;
                     d.half_vld = 1'b1;
                  end else begin
                     emit       = 1'b1;
                     d.half_vld = 1'b0;
                     emit_color = (C_color_bits == 16) ? C_color_bits'({q.half, q.byte_dat})
                                                       : C_color_bits'(q.byte_dat);
                  end
               end
               default: ;
            endcase
         end
      end else if (cs_s) begin
         d.half_vld = 1'b0;
      end

      // Pixel strobe carries the pre-advance pointer, then the pointer walks the window
      if (emit) begin
         d.pixel_valid = 1'b1;
         d.px_x        = q.x;
         d.px_y        = q.y;
         d.px_color    = emit_color;
         if (q.x < q.xe) begin
            d.x = q.x + C_x_bits'(1);
         end else begin
            d.x = q.xs;
            if (q.y < q.ye) begin
               d.y = q.y + C_y_bits'(1);
            end else begin
               d.y          = q.ys;
               d.frame_done = 1'b1;
            end
         end
      end
   end

   assign cmd_valid   = q.cmd_valid;
   assign cmd         = q.cmd;
   assign pixel_valid = q.pixel_valid;
   assign px_x        = q.px_x;
   assign px_y        = q.px_y;
   assign px_color    = q.px_color;
   assign frame_done  = q.frame_done;

endmodule

// File: tb/tb_st7735_sink.sv
// Randomized bench for st7735_sink: drives the SPI link and checks pixel/command
// strobes against a byte-level behavioural model of the panel protocol.
module tb_st7735_sink;

   localparam int unsigned XB = 8;
   localparam int unsigned YB = 8;
   localparam int unsigned CB = 16;

   logic          clk = 1'b0;
   logic          resetn, oled_cs, oled_clk, oled_mosi, oled_dc, lcd_resetn;
   logic          cmd_valid, pixel_valid, frame_done;
   logic [7:0]    cmd;
   logic [XB-1:0] px_x;
   logic [YB-1:0] px_y;
   logic [CB-1:0] px_color;

   st7735_sink #(.C_color_bits(CB), .C_x_bits(XB), .C_y_bits(YB)) dut (
      .clk(clk), .resetn(resetn), .oled_cs(oled_cs), .oled_clk(oled_clk),
      .oled_mosi(oled_mosi), .oled_dc(oled_dc), .lcd_resetn(lcd_resetn),
      .cmd_valid(cmd_valid), .cmd(cmd), .pixel_valid(pixel_valid),
      .px_x(px_x), .px_y(px_y), .px_color(px_color), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int y; int color; int fd; int lat; } pix_t;
   typedef struct { int code; int lat; } cmd_t;

   pix_t obs_pix[$], exp_pix[$];
   cmd_t obs_cmd[$], exp_cmd[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_rise = 0;

   // Model state: window, pointer, decode mode and pending bytes
   int m_mode;   // 0 idle, 1 caset, 2 raset, 3 ramwr, 4 skip
   int m_args[4];
   int m_argn;
   int m_xs, m_xe, m_ys, m_ye, m_px, m_py;
   bit m_half_v;
   int m_half;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Latency is counted from the first clk edge that sees the completing sclk high
   always @(negedge clk) begin
      if (pixel_valid)
         obs_pix.push_back('{int'(px_x), int'(px_y), int'(px_color), int'(frame_done),
                             cyc - last_rise - 1});
      if (cmd_valid)
         obs_cmd.push_back('{int'(cmd), cyc - last_rise - 1});
   end

   function automatic void model_reset();
      m_mode = 0; m_argn = 0;
      m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159;
      m_px = 0; m_py = 0;
      m_half_v = 1'b0; m_half = 0;
   endfunction

   function automatic void model_emit(input int color);
      int fd = 0;
      int x0 = m_px;
      int y0 = m_py;
      if (m_px < m_xe) m_px++;
      else begin
         m_px = m_xs;
         if (m_py < m_ye) m_py++;
         else begin
            m_py = m_ys;
            fd = 1;
         end
      end
      exp_pix.push_back('{x0, y0, color, fd, 4});
   endfunction

   function automatic void model_byte(input bit dc, input int b);
      int v0, v1;
      if (!dc) begin
         exp_cmd.push_back('{b, 4});
         m_half_v = 1'b0;
         m_argn = 0;
         case (b)
            'h2A: m_mode = 1;
            'h2B: m_mode = 2;
            'h2C: begin m_mode = 3; m_px = m_xs; m_py = m_ys; end
            default: m_mode = 4;
         endcase
      end else if (m_mode == 1 || m_mode == 2) begin
         m_args[m_argn] = b;
         m_argn++;
         if (m_argn == 4) begin
            v0 = m_args[0] * 256 + m_args[1];
            v1 = m_args[2] * 256 + m_args[3];
            if (m_mode == 1) begin m_xs = v0 % (1 << XB); m_xe = v1 % (1 << XB); end
            else             begin m_ys = v0 % (1 << YB); m_ye = v1 % (1 << YB); end
            m_mode = 0;
         end
      end else if (m_mode == 3) begin
         if (!m_half_v) begin m_half = b; m_half_v = 1'b1; end
         else begin model_emit(m_half * 256 + b); m_half_v = 1'b0; end
      end
   endfunction

   task automatic spi_bits(input bit dc, input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         oled_mosi = b[i]; oled_dc = dc; oled_clk = 1'b0;
         repeat (3) @(negedge clk);
         oled_clk = 1'b1;
         if (i == 0) last_rise = cyc;
         repeat (3) @(negedge clk);
      end
      oled_clk = 1'b0;
   endtask

   task automatic spi_byte(input bit dc, input int b);
      spi_bits(dc, 8'(b), 8);
      model_byte(dc, b);
   endtask

   task automatic cs_low();
      oled_cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      oled_clk = 1'b0;
      oled_cs  = 1'b1;
      m_half_v = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic send_window(input int cmd_b, input int hs, input int ls, input int he, input int le);
      spi_byte(1'b0, cmd_b);
      spi_byte(1'b1, hs); spi_byte(1'b1, ls);
      spi_byte(1'b1, he); spi_byte(1'b1, le);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_cmd_valid"},   int'(cmd_valid),   0);
      check({tag, "_cmd"},         int'(cmd),         0);
      check({tag, "_pixel_valid"}, int'(pixel_valid), 0);
      check({tag, "_px_x"},        int'(px_x),        0);
      check({tag, "_px_y"},        int'(px_y),        0);
      check({tag, "_px_color"},    int'(px_color),    0);
      check({tag, "_frame_done"},  int'(frame_done),  0);
   endtask

   task automatic drain_check(input string tag);
      pix_t o, e;
      cmd_t oc, ec;
      repeat (12) @(negedge clk);
      check({tag, "_npix"}, obs_pix.size(), exp_pix.size());
      check({tag, "_ncmd"}, obs_cmd.size(), exp_cmd.size());
      while (obs_pix.size() > 0 && exp_pix.size() > 0) begin
         o = obs_pix.pop_front();
         e = exp_pix.pop_front();
         check({tag, "_x"},     o.x,     e.x);
         check({tag, "_y"},     o.y,     e.y);
         check({tag, "_color"}, o.color, e.color);
         check({tag, "_fd"},    o.fd,    e.fd);
         check({tag, "_lat"},   o.lat,   e.lat);
      end
      while (obs_cmd.size() > 0 && exp_cmd.size() > 0) begin
         oc = obs_cmd.pop_front();
         ec = exp_cmd.pop_front();
         check({tag, "_cmd"},     oc.code, ec.code);
         check({tag, "_cmd_lat"}, oc.lat,  ec.lat);
      end
      obs_pix.delete(); exp_pix.delete();
      obs_cmd.delete(); exp_cmd.delete();
   endtask

   initial begin
      int xs, xe, ys, ye, npix;
      resetn = 1'b0; oled_cs = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0;
      oled_dc = 1'b0; lcd_resetn = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      check_outputs_zero("rst");
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      check_outputs_zero("rst_rel");

      // resetn mid-RAMWR, then data with no new RAMWR
      cs_low();
      spi_byte(1'b0, 'h2C);
      spi_byte(1'b1, 'h11); spi_byte(1'b1, 'h22); spi_byte(1'b1, 'h33);
      drain_check("t1a");
      cs_high();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("t1_rst");
      model_reset();
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      check_outputs_zero("t1_rel");
      cs_low();
      spi_byte(1'b1, 'h44); spi_byte(1'b1, 'h55);
      drain_check("t1b");

      // Small window, frame wrap
      send_window('h2A, 'h00, 'h02, 'h00, 'h04);
      send_window('h2B, 'h00, 'h05, 'h00, 'h06);
      spi_byte(1'b0, 'h2C);
      for (int i = 0; i < 6; i++) begin spi_byte(1'b1, 'hF8); spi_byte(1'b1, 'h00); end
      drain_check("t2");
      for (int i = 0; i < 2; i++) begin spi_byte(1'b1, 'hF8); spi_byte(1'b1, 'h00); end
      drain_check("t3");

      // cs high drops a pending half and a partial byte
      spi_byte(1'b0, 'h2C);
      spi_byte(1'b1, 'hAB);
      cs_high(); cs_low();
      spi_byte(1'b1, 'h12); spi_byte(1'b1, 'h34);
      spi_byte(1'b1, 'h56);
      spi_bits(1'b1, 8'hE7, 4);
      cs_high(); cs_low();
      spi_byte(1'b1, 'h9A); spi_byte(1'b1, 'hBC);
      drain_check("t4");

      // Unknown command with data leaves the window alone
      spi_byte(1'b0, 'h36); spi_byte(1'b1, 'h08);
      spi_byte(1'b0, 'h2C);
      spi_byte(1'b1, 'h07); spi_byte(1'b1, 'hE0);
      drain_check("t5");

      // lcd_resetn pulse restores the full-panel window
      cs_high();
      lcd_resetn = 1'b0;
      repeat (6) @(negedge clk);
      check_outputs_zero("t6_lrst");
      model_reset();
      lcd_resetn = 1'b1;
      repeat (6) @(negedge clk);
      cs_low();
      spi_byte(1'b0, 'h2C);
      for (int i = 0; i < 129; i++) begin
         spi_byte(1'b1, int'($urandom_range(0, 255)));
         spi_byte(1'b1, int'($urandom_range(0, 255)));
      end
      drain_check("t6");

      // Random windows (including XS>XE / YS>YE), stray commands and cs gaps
      for (int r = 0; r < 12; r++) begin
         xs = int'($urandom_range(0, 7)); xe = int'($urandom_range(0, 7));
         ys = int'($urandom_range(0, 7)); ye = int'($urandom_range(0, 7));
         send_window('h2A, int'($urandom_range(0, 255)), xs, int'($urandom_range(0, 255)), xe);
         if ($urandom_range(0, 2) == 0) spi_byte(1'b1, int'($urandom_range(0, 255)));
         send_window('h2B, int'($urandom_range(0, 255)), ys, int'($urandom_range(0, 255)), ye);
         if ($urandom_range(0, 2) == 0) begin
            spi_byte(1'b0, ($urandom_range(0, 1) == 0) ? 'h3A : 'h29);
            spi_byte(1'b1, int'($urandom_range(0, 255)));
         end
         spi_byte(1'b0, 'h2C);
         npix = int'($urandom_range(1, 12));
         for (int p = 0; p < 2 * npix; p++) begin
            spi_byte(1'b1, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) begin cs_high(); cs_low(); end
         end
         drain_check($sformatf("rnd%0d", r));
      end
      cs_high();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
